// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver. A frame is a start bit, 8 data bits
// sent LSB first, one parity bit and STOP_CHECK checked stop bits.
// The optional macro UART_RX_MAJORITY_EN makes every mid-bit sample a 2-of-3
// vote over three consecutive ticks. Each decision then happens one tick
// later. Without the macro, each decision uses a single rx_s sample.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_CHECK = 1
) (
    input  logic       baud_clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(OVERSAMPLE / 2);
`else
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(7);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_CHECK - 1);
    localparam logic             PAR_ODD   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_WAIT_HIGH,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_e;

    logic             sync1_q, sync2_q;
    logic             rx_s;
    logic             sample_bit;
    logic             cnt_wrap;
    logic             exp_par;
    logic [CNT_W-1:0] cnt_inc;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [BIT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0]       shift_q,     shift_d;
    logic             perr_pend_q, perr_pend_d;
    logic             ferr_pend_q, ferr_pend_d;
    logic [7:0]       data_q,      data_d;
    logic             valid_q,     valid_d;
    logic             perr_q,      perr_d;
    logic             ferr_q,      ferr_d;
    logic             busy_q,      busy_d;

    // Two-flop synchronizer for the asynchronous line; resets to idle-high
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // History of rx_s for the 2-of-3 vote (hist_q[0] is one tick old)
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample_bit = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample_bit = rx_s;
`endif

    assign cnt_wrap = (cnt_q == CNT_LAST);
    assign cnt_inc  = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    assign exp_par  = (^shift_q) ^ PAR_ODD;

    // State and output registers
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state_q     <= S_WAIT_HIGH;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            busy_q      <= busy_d;
        end
    end

    // Frame sequencing: next state, bit timing and completion update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        case (state_q)
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d     = S_START;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_START) begin
                    cnt_d   = '0;
                    state_d = sample_bit ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                cnt_d = cnt_inc;
                if (cnt_wrap) begin
                    shift_d = {sample_bit, shift_q[7:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                cnt_d = cnt_inc;
                if (cnt_wrap) begin
                    perr_pend_d = sample_bit ^ exp_par;
                    bit_cnt_d   = '0;
                    state_d     = S_STOP;
                end
            end
            S_STOP: begin
                cnt_d = cnt_inc;
                if (cnt_wrap) begin
                    if (!sample_bit) begin
                        ferr_pend_d = 1'b1;
                    end
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_DONE: begin
                data_d  = shift_q;
                perr_d  = perr_pend_q;
                ferr_d  = ferr_pend_q;
                valid_d = 1'b1;
                state_d = ferr_pend_q ? S_WAIT_HIGH : S_IDLE;
            end
            default: begin
                state_d = S_WAIT_HIGH;
            end
        endcase
    end

    // Busy whenever the receiver is anywhere but idle after this tick
    assign busy_d = (state_d != S_IDLE);

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign rx_busy    = busy_q;

endmodule
